// File: rtl/mem_access_unit_pkg.sv
// Shared MEM-stage definitions: FSM encoding, default parameters and the
// ALU-result to data-memory word-address mapping.
package mem_access_unit_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mau_state_e;

    localparam int unsigned ADDR_OFFSET_DEF = 1024;
    localparam int unsigned TIMEOUT_DEF     = 255;

    // Word address = bits [17:2] of the offset-corrected byte address.
    function automatic logic [15:0] mem_word_addr(input logic [31:0] alu_res,
                                                  input logic [31:0] offset);
        return 16'((alu_res - offset) >> 2);
    endfunction

endpackage

// File: rtl/mem_access_unit_mem_wb.sv
// MEM/WB pipeline register: loads the stage results, or inserts a bubble that
// clears only the writeback and load-enable controls.
module mem_wb_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        bubble_i,
    input  logic        data_load_i,
    input  logic        wb_en_i,
    input  logic        mem_r_en_i,
    input  logic [31:0] alu_res_i,
    input  logic [31:0] mem_data_i,
    input  logic [3:0]  dest_i,
    output logic        wb_en_o,
    output logic        mem_r_en_o,
    output logic [31:0] alu_res_o,
    output logic [31:0] mem_data_o,
    output logic [3:0]  dest_o
);
    logic        wb_en_q, mem_r_en_q;
    logic [31:0] alu_res_q, mem_data_q;
    logic [3:0]  dest_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            alu_res_q  <= '0;
            mem_data_q <= '0;
            dest_q     <= '0;
        end else begin
            if (bubble_i) begin
                wb_en_q    <= 1'b0;
                mem_r_en_q <= 1'b0;
            end else if (load_i) begin
                wb_en_q    <= wb_en_i;
                mem_r_en_q <= mem_r_en_i;
                alu_res_q  <= alu_res_i;
                dest_q     <= dest_i;
            end
            if (data_load_i) begin
                mem_data_q <= mem_data_i;
            end
        end
    end

    assign wb_en_o    = wb_en_q;
    assign mem_r_en_o = mem_r_en_q;
    assign alu_res_o  = alu_res_q;
    assign mem_data_o = mem_data_q;
    assign dest_o     = dest_q;

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: issues one external access per LDR/STR and stalls the
// front of the pipe until the ack arrives or the wait budget runs out.
//
// state | meaning
// IDLE  | no access outstanding; non-memory results pass straight to MEM/WB
// WAIT  | request outstanding; ack budget counting down toward abort
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned ADDR_OFFSET = ADDR_OFFSET_DEF,
    parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [31:0] alu_res_i,
    input  logic [31:0] rm_val_i,
    input  logic        mem_r_en_i,
    input  logic        mem_w_en_i,
    input  logic        wb_en_i,
    input  logic [3:0]  dest_i,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [15:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        wb_en_o,
    output logic        mem_r_en_o,
    output logic [31:0] alu_res_o,
    output logic [31:0] mem_data_o,
    output logic [3:0]  dest_o,
    output logic        err_o
);
    localparam logic [31:0] OFFSET_C  = 32'(ADDR_OFFSET);
    localparam logic [7:0]  TIMEOUT_C = 8'(TIMEOUT);

    mau_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        mem_op, stall, wb_load, wb_bubble, wb_data_load, wb_kill;

    assign mem_op = valid_i & (mem_r_en_i | mem_w_en_i);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // The wait budget is a down-counter: loaded on issue, abort when it hits zero.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        we_d         = we_q;
        err_d        = err_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        stall        = 1'b0;
        wb_load      = 1'b0;
        wb_bubble    = 1'b0;
        wb_data_load = 1'b0;
        wb_kill      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_op) begin
                    stall     = 1'b1;
                    wb_bubble = 1'b1;
                    state_d   = ST_WAIT;
                    cnt_d     = TIMEOUT_C;
                    req_d     = 1'b1;
                    we_d      = mem_w_en_i & ~mem_r_en_i;
                    addr_d    = mem_word_addr(alu_res_i, OFFSET_C);
                    wdata_d   = rm_val_i;
                end else if (valid_i) begin
                    wb_load = 1'b1;
                end else begin
                    wb_bubble = 1'b1;
                end
            end
            ST_WAIT: begin
                if (mem_ack_i) begin
                    wb_load      = 1'b1;
                    wb_data_load = ~we_q;
                    state_d      = ST_IDLE;
                    req_d        = 1'b0;
                    we_d         = 1'b0;
                end else if (cnt_q == 8'd0) begin
                    wb_load = 1'b1;
                    wb_kill = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                end else begin
                    stall     = 1'b1;
                    wb_bubble = 1'b1;
                    cnt_d     = cnt_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset must release the pipeline in the same cycle, even with a mem op presented.
    assign stall_o     = rst & stall;
    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign err_o       = err_q;

    mem_wb_reg u_mem_wb (
        .clk         (clk),
        .rst         (rst),
        .load_i      (wb_load),
        .bubble_i    (wb_bubble),
        .data_load_i (wb_data_load),
        .wb_en_i     (wb_en_i & ~wb_kill),
        .mem_r_en_i  (mem_r_en_i),
        .alu_res_i   (alu_res_i),
        .mem_data_i  (mem_rdata_i),
        .dest_i      (dest_i),
        .wb_en_o     (wb_en_o),
        .mem_r_en_o  (mem_r_en_o),
        .alu_res_o   (alu_res_o),
        .mem_data_o  (mem_data_o),
        .dest_o      (dest_o)
    );

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector tables, directed multi-cycle
// sequences and randomized transactions against a transaction-level model.
module tb_mem_access_unit;

    localparam int          TMO = 4;
    localparam logic [31:0] OFS = 32'd1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic [31:0] alu_res_i = '0;
    logic [31:0] rm_val_i = '0;
    logic        mem_r_en_i = 1'b0;
    logic        mem_w_en_i = 1'b0;
    logic        wb_en_i = 1'b0;
    logic [3:0]  dest_i = '0;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_ack_i = 1'b0;
    logic        stall_o, mem_req_o, mem_we_o, wb_en_o, mem_r_en_o, err_o;
    logic [15:0] mem_addr_o;
    logic [31:0] mem_wdata_o, alu_res_o, mem_data_o;
    logic [3:0]  dest_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_mem_data = '0;
    logic        exp_err = 1'b0;

    typedef struct {
        logic [31:0] alu;
        logic        wb;
        logic [3:0]  dest;
        logic [31:0] e_alu;
        logic        e_wb;
        logic [3:0]  e_dest;
    } alu_vec_t;

    typedef struct {
        logic [31:0] alu;
        logic [15:0] e_addr;
    } addr_vec_t;

    alu_vec_t  alu_tab [4];
    addr_vec_t addr_tab [7];

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_OFFSET(1024), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (valid_i),
        .alu_res_i   (alu_res_i),
        .rm_val_i    (rm_val_i),
        .mem_r_en_i  (mem_r_en_i),
        .mem_w_en_i  (mem_w_en_i),
        .wb_en_i     (wb_en_i),
        .dest_i      (dest_i),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i),
        .wb_en_o     (wb_en_o),
        .mem_r_en_o  (mem_r_en_o),
        .alu_res_o   (alu_res_o),
        .mem_data_o  (mem_data_o),
        .dest_o      (dest_o),
        .err_o       (err_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_addr(input logic [31:0] alu);
        logic [31:0] byte_addr;
        byte_addr = alu - OFS;
        return 16'((byte_addr / 32'd4) % 32'd65536);
    endfunction

    task automatic idle(input int n);
        valid_i = 1'b0; mem_r_en_i = 1'b0; mem_w_en_i = 1'b0; wb_en_i = 1'b0; mem_ack_i = 1'b0;
        repeat (n) begin
            #1 chk("idle_stall", 32'(stall_o), 32'd0);
            @(negedge clk);
            chk("bubble_wb", 32'(wb_en_o), 32'd0);
            chk("bubble_rd", 32'(mem_r_en_o), 32'd0);
            chk("idle_req", 32'(mem_req_o), 32'd0);
        end
    endtask

    task automatic do_alu(input logic [31:0] alu, input logic wb, input logic [3:0] dest,
                          input logic [31:0] e_alu, input logic e_wb, input logic [3:0] e_dest);
        valid_i = 1'b1; mem_r_en_i = 1'b0; mem_w_en_i = 1'b0; mem_ack_i = 1'b0;
        alu_res_i = alu; wb_en_i = wb; dest_i = dest; rm_val_i = $urandom;
        #1;
        chk("alu_stall", 32'(stall_o), 32'd0);
        @(negedge clk);
        chk("alu_res", alu_res_o, e_alu);
        chk("alu_wb", 32'(wb_en_o), 32'(e_wb));
        chk("alu_dest", 32'(dest_o), 32'(e_dest));
        chk("alu_rd", 32'(mem_r_en_o), 32'd0);
        chk("alu_data_kept", mem_data_o, exp_mem_data);
        chk("alu_no_req", 32'(mem_req_o), 32'd0);
        chk("alu_err", 32'(err_o), 32'(exp_err));
    endtask

    // d = number of WAIT cycles without ack before the ack; d > TMO means never.
    task automatic do_mem(input logic [31:0] alu, input logic [15:0] ea, input logic [31:0] wdata,
                          input logic r, input logic w, input logic wb, input logic [3:0] dest,
                          input logic [31:0] rdata, input int d);
        int stalls;
        int exp_stalls;
        bit ok;
        valid_i = 1'b1; mem_r_en_i = r; mem_w_en_i = w; alu_res_i = alu; rm_val_i = wdata;
        wb_en_i = wb; dest_i = dest; mem_ack_i = 1'b0; mem_rdata_i = $urandom;
        #1;
        chk("req_gap", 32'(mem_req_o), 32'd0);
        stalls = stall_o ? 1 : 0;
        for (int k = 0; k <= TMO; k++) begin
            @(negedge clk);
            chk("wait_req", 32'(mem_req_o), 32'd1);
            chk("wait_we", 32'(mem_we_o), 32'(w & ~r));
            chk("wait_addr", 32'(mem_addr_o), 32'(ea));
            chk("wait_wdata", mem_wdata_o, wdata);
            chk("wait_wb", 32'(wb_en_o), 32'd0);
            if (k == d) begin
                mem_ack_i = 1'b1;
                mem_rdata_i = rdata;
            end
            #1;
            if (!stall_o) break;
            stalls++;
        end
        @(negedge clk);
        mem_ack_i = 1'b0;
        ok = (d <= TMO);
        exp_stalls = 1 + (ok ? d : TMO);
        if (ok && r) exp_mem_data = rdata;
        if (!ok) exp_err = 1'b1;
        chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
        chk("done_req", 32'(mem_req_o), 32'd0);
        chk("done_wb", 32'(wb_en_o), 32'(ok ? wb : 1'b0));
        chk("done_rd", 32'(mem_r_en_o), 32'(r));
        chk("done_dest", 32'(dest_o), 32'(dest));
        chk("done_alu", alu_res_o, alu);
        chk("done_data", mem_data_o, exp_mem_data);
        chk("done_err", 32'(err_o), 32'(exp_err));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"}, 32'(mem_req_o), 32'd0);
        chk({tag, "_stall"}, 32'(stall_o), 32'd0);
        chk({tag, "_we"}, 32'(mem_we_o), 32'd0);
        chk({tag, "_addr"}, 32'(mem_addr_o), 32'd0);
        chk({tag, "_wdata"}, mem_wdata_o, 32'd0);
        chk({tag, "_err"}, 32'(err_o), 32'd0);
        chk({tag, "_wb"}, 32'(wb_en_o), 32'd0);
        chk({tag, "_rd"}, 32'(mem_r_en_o), 32'd0);
        chk({tag, "_alu"}, alu_res_o, 32'd0);
        chk({tag, "_data"}, mem_data_o, 32'd0);
        chk({tag, "_dest"}, 32'(dest_o), 32'd0);
    endtask

    initial begin
        alu_tab[0] = '{32'd5,          1'b1, 4'd3,  32'd5,          1'b1, 4'd3};
        alu_tab[1] = '{32'hFFFF_FFFF,  1'b0, 4'd15, 32'hFFFF_FFFF,  1'b0, 4'd15};
        alu_tab[2] = '{32'd0,          1'b1, 4'd0,  32'd0,          1'b1, 4'd0};
        alu_tab[3] = '{32'h8000_0001,  1'b1, 4'd9,  32'h8000_0001,  1'b1, 4'd9};
        addr_tab[0] = '{32'd1024,       16'h0000};
        addr_tab[1] = '{32'd1027,       16'h0000};
        addr_tab[2] = '{32'd1028,       16'h0001};
        addr_tab[3] = '{32'd1032,       16'h0002};
        addr_tab[4] = '{32'd0,          16'hFF00};
        addr_tab[5] = '{32'h0004_0400,  16'h0000};
        addr_tab[6] = '{32'h1234_5678,  16'h149E};

        #2 rst = 1'b0;
        #1 chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        idle(1);

        foreach (alu_tab[i])
            do_alu(alu_tab[i].alu, alu_tab[i].wb, alu_tab[i].dest,
                   alu_tab[i].e_alu, alu_tab[i].e_wb, alu_tab[i].e_dest);
        idle(1);

        foreach (addr_tab[i])
            do_mem(addr_tab[i].alu, addr_tab[i].e_addr, 32'h0, 1'b1, 1'b0, 1'b1, 4'd1,
                   32'h100 + 32'(i), 0);

        // STR acked after 3 wait cycles
        do_mem(32'd1028, 16'd1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 4'd2, 32'h5555_AAAA, 3);
        idle(1);
        // LDR acked on the 2nd wait cycle
        do_mem(32'd1032, 16'd2, 32'h0, 1'b1, 1'b0, 1'b1, 4'd7, 32'h1234_5678, 1);

        // Ack while idle must be ignored
        valid_i = 1'b0; mem_r_en_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'hA5A5_A5A5;
        #1 chk("idle_ack_stall", 32'(stall_o), 32'd0);
        @(negedge clk);
        mem_ack_i = 1'b0;
        chk("idle_ack_data", mem_data_o, exp_mem_data);
        chk("idle_ack_req", 32'(mem_req_o), 32'd0);

        // Both enables set: read only
        do_mem(32'd1036, 16'd3, 32'h7777_0000, 1'b1, 1'b1, 1'b1, 4'd4, 32'h0BAD_F00D, 0);

        // Back-to-back loads, each acked after one wait cycle
        do_mem(32'd1040, 16'd4, 32'h0, 1'b1, 1'b0, 1'b1, 4'd8, 32'h1111_1111, 1);
        do_mem(32'd1044, 16'd5, 32'h0, 1'b1, 1'b0, 1'b1, 4'd9, 32'h2222_2222, 1);
        idle(1);

        // LDR that never gets acked
        do_mem(32'd1048, 16'd6, 32'h0, 1'b1, 1'b0, 1'b1, 4'd5, 32'h0, TMO + 1);
        do_alu(32'd42, 1'b1, 4'd6, 32'd42, 1'b1, 4'd6);

        // Reset in the 2nd WAIT cycle of a store
        valid_i = 1'b1; mem_r_en_i = 1'b0; mem_w_en_i = 1'b1; alu_res_i = 32'd1052;
        rm_val_i = 32'hCAFE_F00D; wb_en_i = 1'b0; dest_i = 4'd11;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_req", 32'(mem_req_o), 32'd1);
        rst = 1'b0;
        exp_mem_data = '0;
        exp_err = 1'b0;
        #1 chk_all_zero("midwait_rst");
        valid_i = 1'b0; mem_w_en_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_ack_i = 1'b0;
        chk_all_zero("late_ack");

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            int          kind;
            int          d;
            logic [31:0] alu;
            logic [3:0]  dst;
            logic        wbr;
            kind = int'($urandom_range(0, 3));
            d    = int'($urandom_range(0, TMO + 1));
            alu  = $urandom;
            dst  = 4'($urandom);
            wbr  = 1'($urandom);
            case (kind)
                0: do_alu(alu, wbr, dst, alu, wbr, dst);
                1: do_mem(alu, model_addr(alu), $urandom, 1'b1, 1'b0, 1'b1, dst, $urandom, d);
                2: do_mem(alu, model_addr(alu), $urandom, 1'b0, 1'b1, wbr, dst, $urandom, d);
                default: do_mem(alu, model_addr(alu), $urandom, 1'b1, 1'b1, wbr, dst, $urandom, d);
            endcase
            if ($urandom_range(0, 1) == 1) idle(1);
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter ADDR_OFFSET, default 1024: byte offset subtracted from ALU result to form the data-memory address.
REQ-002 Parameter TIMEOUT, default 255: maximum wait cycles for mem_ack before abort; 8-bit range.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 valid_i  in  1  EXE stage presents an instruction this cycle.
REQ-006 alu_res_i  in  32  ALU result (address for LDR/STR, data for others).
REQ-007 rm_val_i  in  32  store data.
REQ-008 mem_r_en_i / mem_w_en_i / wb_en_i  in  1 each  load, store and writeback enables from EXE.
REQ-009 dest_i  in  4  destination register.
REQ-010 stall_o  out  1  freeze request to IF/ID/EXE and their pipeline registers.
REQ-011 mem_req_o, mem_we_o  out  1 each  external memory request and write strobe.
REQ-012 mem_addr_o  out  16  word address; mem_wdata_o  out  32  store data.
REQ-013 mem_rdata_i  in  32, mem_ack_i  in  1  read data and one-cycle completion strobe.
REQ-014 wb_en_o, mem_r_en_o  out  1 each; alu_res_o, mem_data_o  out  32; dest_o  out  4  registered MEM/WB outputs.
REQ-015 err_o  out  1  sticky timeout flag.

Function
REQ-016 Mem op = valid_i & (mem_r_en_i | mem_w_en_i); both enables set SHALL perform a read only.
REQ-017 mem_addr_o SHALL equal bits [17:2] of (alu_res_i - ADDR_OFFSET), 32-bit modulo subtraction, low two bits ignored.
REQ-018 FSM states: IDLE, WAIT; reset state IDLE.
REQ-019 IDLE, non-mem valid op: at next edge, MEM/WB register loads inputs (wb_en_o = wb_en_i, mem_data_o unchanged); latency 1 cycle; stall_o = 0.
REQ-020 IDLE, no valid op: MEM/WB register loads a bubble (wb_en_o = 0, mem_r_en_o = 0).
REQ-021 IDLE, mem op: stall_o = 1 combinationally; at next edge, latch address, wdata and we; assert mem_req_o; clear wait counter; go to WAIT; MEM/WB loads bubble.
REQ-022 WAIT: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o held stable; counter increments each cycle without mem_ack_i.
REQ-023 WAIT with mem_ack_i = 1: stall_o = 0 that cycle; at the edge, MEM/WB loads inputs, mem_data_o = mem_rdata_i for reads (unchanged for writes); mem_req_o drops; go to IDLE.
REQ-024 WAIT with no ack: stall_o = 1; MEM/WB loads bubble.
REQ-025 WAIT with counter = TIMEOUT and no ack: stall_o = 0; at the edge, err_o <= 1, mem_req_o drops, MEM/WB loads inputs with wb_en_o forced 0; go to IDLE.
REQ-026 mem_ack_i in IDLE SHALL be ignored.
REQ-027 Upstream holds all *_i stable while stall_o = 1; the unit relies on this only for dest_i/wb_en_i/alu_res_i at completion.

Reset
REQ-028 rst low SHALL immediately force IDLE, counter 0, mem_req_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0, err_o = 0, all MEM/WB outputs 0, including mid-WAIT.
REQ-029 err_o SHALL clear only on reset.

Structure
REQ-030 State encoding, ADDR_OFFSET and TIMEOUT defaults belong in the shared processor package.
REQ-031 The MEM/WB output register SHALL be a sub-module mem_wb_reg with load and bubble controls.

Verification
REQ-032 ADD with alu_res_i = 0x0000_0005, wb_en_i = 1, dest_i = 3 -> next cycle alu_res_o = 5, wb_en_o = 1, dest_o = 3, no mem_req_o.
REQ-033 STR with alu_res_i = 1028, rm_val_i = 0xDEAD_BEEF, ack after 3 cycles -> mem_addr_o = 1, mem_we_o = 1, stall_o high 4 cycles, wb_en_o = 0 throughout.
REQ-034 LDR with alu_res_i = 1032, dest_i = 7, mem_rdata_i = 0x1234_5678, ack on 2nd WAIT cycle -> mem_addr_o = 2; next edge mem_data_o = 0x1234_5678, mem_r_en_o = 1, wb_en_o = 1, dest_o = 7.
REQ-035 LDR, ack never arrives, TIMEOUT = 4 -> stall released after 5 cycles, err_o = 1, wb_en_o = 0, mem_req_o = 0.
REQ-036 rst low in 2nd WAIT cycle -> same cycle mem_req_o = 0, stall_o = 0, all outputs 0; a later mem_ack_i has no effect.
REQ-037 Back-to-back LDR, LDR, each acked after 1 cycle -> two distinct requests with mem_req_o low for at least one cycle between them; both results appear in order.
